// File: rtl/lifo_stack.sv
// lifo_stack: parameterised LIFO stack for the core's return-address and
// operand stack.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  log2 of the entry count; the stack holds 2**DEPTH words (DEPTH >= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset of count and error flags
//   en         operation enable; push/pop are ignored while low
//   push       push d, or replace the top entry when pop is also high
//   pop        discard the top entry
//   d          data to push or replace with
//   clr_err    clears the sticky overflow/underflow flags (honoured even when en=0)
//   q          top entry, 0 when empty
//   q_next     entry below the top, 0 when fewer than two entries
//   count      number of valid entries, 0..2**DEPTH
//   empty      count == 0
//   full       count == 2**DEPTH
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
module lifo_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next,
  output logic [DEPTH:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int             ENTRIES = 2 ** DEPTH;
  localparam logic [DEPTH:0] CNT_MAX = (DEPTH + 1)'(ENTRIES);
  localparam logic [DEPTH:0] CNT_TWO = (DEPTH + 1)'(2);

  logic [WIDTH-1:0] mem [ENTRIES];

  logic [DEPTH-1:0] top_idx;
  logic [DEPTH-1:0] next_idx;
  logic [DEPTH-1:0] wr_idx;

  logic do_push;
  logic do_pop;
  logic do_replace;
  logic push_on_empty;
  logic wr_en;
  logic ovf_evt;
  logic udf_evt;

  // Index arithmetic is done modulo 2**DEPTH: when the stack is full the
  // low DEPTH bits of count are zero, so count-1 wraps to the last slot,
  // which is exactly the top entry.
  assign top_idx  = count[DEPTH-1:0] - DEPTH'(1);
  assign next_idx = count[DEPTH-1:0] - DEPTH'(2);

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  assign q      = empty             ? '0 : mem[top_idx];
  assign q_next = (count < CNT_TWO) ? '0 : mem[next_idx];

  // Operation decode. A push+pop on an empty stack degenerates into a plain
  // push; on a non-empty stack it overwrites the top and can never overflow.
  assign do_push       = en &  push & ~pop & ~full;
  assign do_pop        = en & ~push &  pop & ~empty;
  assign do_replace    = en &  push &  pop & ~empty;
  assign push_on_empty = en &  push &  pop &  empty;
  assign ovf_evt       = en &  push & ~pop &  full;
  assign udf_evt       = en & ~push &  pop &  empty;

  assign wr_en  = do_push | do_replace | push_on_empty;
  assign wr_idx = do_replace ? top_idx : count[DEPTH-1:0];

  // Control state: occupancy and sticky error flags. A same-cycle error
  // takes priority over clr_err so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push | push_on_empty) begin
        count <= count + (DEPTH + 1)'(1);
      end else if (do_pop) begin
        count <= count - (DEPTH + 1)'(1);
      end

      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (udf_evt) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Storage: not reset, contents beyond count are masked. Writes are gated
  // by reset so an edge arriving while reset is held cannot leave stale data.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= d;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Testbench for lifo_stack (WIDTH=32, DEPTH=3): directed scenarios followed
// by randomized operations, checked against a queue-based stack model via a
// scoreboard of expected per-cycle outputs.
module tb_lifo_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int ENTRIES = 2 ** DEPTH;

  logic             clk;
  logic             reset;
  logic             en;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [DEPTH:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .push      (push),
    .pop       (pop),
    .d         (d),
    .clr_err   (clr_err),
    .q         (q),
    .q_next    (q_next),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    int               cnt;
    bit               e;
    bit               f;
    bit               o;
    bit               u;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a plain queue where the last element is the top.
  logic [WIDTH-1:0] stk[$];
  bit               m_ovf;
  bit               m_udf;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act !== expv) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t r;
    int   n;
    n     = stk.size();
    r.cnt = n;
    r.q   = (n >= 1) ? stk[n-1] : '0;
    r.qn  = (n >= 2) ? stk[n-2] : '0;
    r.e   = (n == 0);
    r.f   = (n == ENTRIES);
    r.o   = m_ovf;
    r.u   = m_udf;
    return r;
  endfunction

  task automatic model_reset();
    stk.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and record what the
  // outputs must look like after the following rising edge.
  task automatic op(input bit e_i, input bit pu, input bit po,
                    input logic [WIDTH-1:0] d_i, input bit clr);
    bit ovf_set;
    bit udf_set;
    @(negedge clk);
    en      = e_i;
    push    = pu;
    pop     = po;
    d       = d_i;
    clr_err = clr;
    ovf_set = 0;
    udf_set = 0;
    if (e_i) begin
      if (pu && !po) begin
        if (stk.size() == ENTRIES) ovf_set = 1;
        else stk.push_back(d_i);
      end else if (!pu && po) begin
        if (stk.size() == 0) udf_set = 1;
        else void'(stk.pop_back());
      end else if (pu && po) begin
        if (stk.size() == 0) stk.push_back(d_i);
        else stk[stk.size()-1] = d_i;
      end
    end
    if (ovf_set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (udf_set) m_udf = 1;
    else if (clr) m_udf = 0;
    exp_q.push_back(model_out());
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 20) begin
      @(posedge clk);
      #2;
      i++;
    end
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every rising edge produces one observable result.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("q",         64'(q),         64'(x.q));
        chk("q_next",    64'(q_next),    64'(x.qn));
        chk("count",     64'(count),     64'(x.cnt));
        chk("empty",     64'(empty),     64'(x.e));
        chk("full",      64'(full),      64'(x.f));
        chk("overflow",  64'(overflow),  64'(x.o));
        chk("underflow", 64'(underflow), 64'(x.u));
      end
    end
  end

  initial begin
    en = 0; push = 0; pop = 0; d = '0; clr_err = 0;
    reset = 1'b0;
    model_reset();
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_q",     64'(q),     64'd0);
    chk("rst_flags", 64'({overflow, underflow}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Three pushes
    op(1, 1, 0, 32'h11, 0);
    op(1, 1, 0, 32'h22, 0);
    op(1, 1, 0, 32'h33, 0);
    drain();
    chk("p3_count",  64'(count),  64'd3);
    chk("p3_q",      64'(q),      64'h33);
    chk("p3_q_next", 64'(q_next), 64'h22);
    chk("p3_ef",     64'({empty, full}), 64'd0);
    for (int i = 0; i < 3; i++) op(1, 0, 1, '0, 0);

    // Fill, overflow, clear
    for (int i = 1; i <= 8; i++) op(1, 1, 0, 32'(i), 0);
    drain();
    chk("fill_full",  64'(full),  64'd1);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_q",     64'(q),     64'd8);
    op(1, 1, 0, 32'd9, 0);
    drain();
    chk("ovf_count", 64'(count),    64'd8);
    chk("ovf_q",     64'(q),        64'd8);
    chk("ovf_flag",  64'(overflow), 64'd1);
    op(0, 0, 0, '0, 1);
    drain();
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Drain to empty, underflow, set-beats-clear
    for (int i = 0; i < 8; i++) op(1, 0, 1, '0, 0);
    op(1, 0, 1, '0, 0);
    drain();
    chk("udf_flag",  64'(underflow), 64'd1);
    chk("udf_count", 64'(count),     64'd0);
    chk("udf_q",     64'(q),         64'd0);
    op(1, 0, 1, '0, 1);
    drain();
    chk("udf_set_wins", 64'(underflow), 64'd1);
    op(0, 0, 0, '0, 1);

    // Replace top
    op(1, 1, 0, 32'hA, 0);
    op(1, 1, 0, 32'hB, 0);
    op(1, 1, 1, 32'hC, 0);
    drain();
    chk("rep_count",  64'(count),  64'd2);
    chk("rep_q",      64'(q),      64'hC);
    chk("rep_q_next", 64'(q_next), 64'hA);
    for (int i = 0; i < 6; i++) op(1, 1, 0, 32'(16 + i), 0);
    op(1, 1, 1, 32'hDD, 0);
    drain();
    chk("rep_full_ovf", 64'(overflow), 64'd0);
    chk("rep_full_q",   64'(q),        64'hDD);
    for (int i = 0; i < 8; i++) op(1, 0, 1, '0, 0);
    op(1, 1, 1, 32'h5, 0);
    drain();
    chk("rep_empty_count", 64'(count), 64'd1);
    chk("rep_empty_q",     64'(q),     64'h5);
    chk("rep_empty_udf",   64'(underflow), 64'd0);

    // Enable gating
    for (int i = 0; i < 4; i++) op(0, 1, 0, 32'hFF, 0);
    drain();
    chk("en0_count", 64'(count), 64'd1);
    chk("en0_q",     64'(q),     64'h5);
    op(1, 1, 0, 32'hFF, 0);
    drain();
    chk("en1_count", 64'(count), 64'd2);
    chk("en1_q",     64'(q),     64'hFF);

    // Asynchronous reset between edges
    op(1, 1, 0, 32'h1, 0);
    op(1, 1, 0, 32'h2, 0);
    op(1, 1, 0, 32'h3, 0);
    op(0, 0, 0, '0, 0);
    drain();
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_q",     64'(q),     64'd0);
    chk("arst_flags", 64'({overflow, underflow}), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    op(1, 1, 0, 32'h7, 0);
    drain();
    chk("post_rst_count",  64'(count),  64'd1);
    chk("post_rst_q",      64'(q),      64'h7);
    chk("post_rst_q_next", 64'(q_next), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
         32'($urandom), ($urandom_range(0, 7) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised hardware LIFO: the successor to the fixed 32-bit, 8-entry stack in the MCCP core.
- Serves as the return-address / operand stack for the core.
- Adds the following over the previous generation:
  - real data storage with readable top and next-of-top
  - occupancy count and full/empty flags
  - combined push+pop "replace top" operation
  - sticky overflow/underflow error flags with clear

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 3, log2 of entry count; stack holds 2**DEPTH entries.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears state immediately.
- en  input  1  operation enable; push/pop ignored when 0.
- push  input  1  push d (or replace top when pop also high).
- pop  input  1  discard top entry.
- d  input  WIDTH  data to push/replace.
- clr_err  input  1  clears overflow/underflow flags.
- q  output  WIDTH  current top entry; 0 when empty.
- q_next  output  WIDTH  entry below top; 0 when count < 2.
- count  output  DEPTH+1  number of valid entries, 0..2**DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == 2**DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset=0, async, no clk needed):
  - count=0, overflow=0, underflow=0, hence empty=1, full=0, q=0, q_next=0.
  - Storage array is not reset; its contents are unobservable while masked by count.
- q, q_next, empty, full: combinational from count and storage; they reflect the new state in the same cycle following the updating edge (zero extra latency).
- Storage: 2**DEPTH x WIDTH registers. Top = mem[count-1], next = mem[count-2].
- Per rising edge, with en=1:
  - push=1, pop=0:
    - not full: mem[count] <= d, count+1.
    - full: no state change, overflow <= 1.
  - push=0, pop=1:
    - not empty: count-1; mem is untouched.
    - empty: no change, underflow <= 1.
  - push=1, pop=1:
    - count >= 1: mem[count-1] <= d, count unchanged (replace top). Never flags an error, even when full.
    - empty: behaves as plain push (count becomes 1, q=d), no underflow.
  - push=0, pop=0: hold.
- en=0: push/pop ignored entirely; no error flags set. clr_err is still honoured.
- clr_err=1 clears both sticky flags on the edge. If an error condition occurs in the same cycle, set wins (flag = 1).
- Arithmetic: count is DEPTH+1 bits, so 2**DEPTH is representable. It never wraps; saturation is enforced by the full/empty guards.
- Reset asserted mid-operation: the in-flight edge is discarded and state goes to reset values. On deassertion, the first operation sees an empty stack.
- Reset deassertion is assumed synchronised externally to clk.

Test Plan:
- Reset then push 0x11,0x22,0x33 (WIDTH=32, DEPTH=3) -> count=3, q=0x33, q_next=0x22, empty=0, full=0.
- Push 8 values 1..8 -> full=1, count=8, q=8. Push 9 -> count stays 8, q=8, overflow=1. Pulse clr_err -> overflow=0.
- From 8 entries, pop 8 times -> q sequence 7,6,...,1 then 0, empty=1. One more pop -> underflow=1, count=0. Same cycle clr_err=1 plus pop on empty -> underflow stays 1.
- Stack holds 0xA,0xB; push=pop=1, d=0xC -> count=2, q=0xC, q_next=0xA. Repeat when full -> no overflow. Repeat when empty with d=0x5 -> count=1, q=0x5.
- en=0 with push=1, d=0xFF for 4 cycles -> count, q, flags unchanged. Then en=1 for one cycle -> count+1, q=0xFF.
- Push 3 values, assert reset low between clock edges -> count=0, q=0, flags=0 immediately, without a clk edge. Release, push 0x7 -> count=1, q=0x7, q_next=0.
